// File: rtl/machine_step_sched.sv
// machine_step_sched: round-robin sequencer driving Machine_step and its event channel; define MACHINE_SCHED_PERF_EN for perf_steps/perf_stalls
module machine_step_sched #(
  parameter int NUM_REQ = 4,
  parameter int SRC_W = 2
) (
  input  logic                  system1000,
  input  logic                  system1000_rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*65-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic                  sched_halt,
  output logic [666:0]          step_ds,
  output logic [64:0]           step_ds1,
  input  logic [794:0]          step_result,
  output logic                  evt_valid,
  input  logic                  evt_ready,
  output logic [94:0]           evt_data,
  output logic [32:0]           evt_aux,
  output logic [SRC_W-1:0]      evt_src,
  output logic                  busy,
`ifdef MACHINE_SCHED_PERF_EN
  output logic [31:0]           perf_steps,
  output logic [31:0]           perf_stalls,
`endif
  output logic [666:0]          machine_state
);
  typedef enum logic [1:0] {IDLE, STEP, EMIT} fsm_e;
  fsm_e fsm_q, fsm_d;
  logic [666:0] state_q, state_d;
  logic [64:0] cmd_q, cmd_d;
  logic [SRC_W-1:0] rr_q, rr_d, src_q, src_d, evt_src_q, evt_src_d, gnt;
  logic evt_valid_q, evt_valid_d;
  logic [94:0] evt_data_q, evt_data_d;
  logic [32:0] evt_aux_q, evt_aux_d;
  int idx;
  always_comb begin
    gnt = '0;
    idx = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(rr_q) + k) % NUM_REQ;
      if (req_valid[idx]) gnt = SRC_W'(idx);
    end
  end
  always_comb begin
    fsm_d = fsm_q;
    state_d = state_q;
    cmd_d = cmd_q;
    rr_d = rr_q;
    src_d = src_q;
    evt_valid_d = evt_valid_q;
    evt_data_d = evt_data_q;
    evt_aux_d = evt_aux_q;
    evt_src_d = evt_src_q;
    req_ready = '0;
    case (fsm_q)
      IDLE: if (!sched_halt && |req_valid) begin
        req_ready[gnt] = 1'b1;
        cmd_d = req_data[65*gnt +: 65];
        src_d = gnt;
        rr_d = gnt;
        fsm_d = STEP;
      end
      STEP: begin
        state_d = step_result[794:128];
        evt_data_d = step_result[127:33];
        evt_aux_d = step_result[32:0];
        evt_src_d = src_q;
        evt_valid_d = |step_result[127:126];
        fsm_d = evt_valid_d ? EMIT : IDLE;
      end
      EMIT: if (evt_ready) begin
        evt_valid_d = 1'b0;
        fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end
  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      fsm_q <= IDLE;
      state_q <= 667'd1;
      cmd_q <= '0;
      rr_q <= SRC_W'(NUM_REQ - 1);
      src_q <= '0;
      evt_valid_q <= 1'b0;
      evt_data_q <= '0;
      evt_aux_q <= '0;
      evt_src_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      state_q <= state_d;
      cmd_q <= cmd_d;
      rr_q <= rr_d;
      src_q <= src_d;
      evt_valid_q <= evt_valid_d;
      evt_data_q <= evt_data_d;
      evt_aux_q <= evt_aux_d;
      evt_src_q <= evt_src_d;
    end
  end
  assign step_ds = state_q;
  assign machine_state = state_q;
  assign step_ds1 = cmd_q;
  assign evt_valid = evt_valid_q;
  assign evt_data = evt_data_q;
  assign evt_aux = evt_aux_q;
  assign evt_src = evt_src_q;
  assign busy = fsm_q != IDLE;
`ifdef MACHINE_SCHED_PERF_EN
  logic [31:0] perf_steps_q, perf_steps_d, perf_stalls_q, perf_stalls_d;
  always_comb begin
    perf_steps_d = perf_steps_q + 32'(fsm_q == STEP);
    perf_stalls_d = perf_stalls_q + 32'(fsm_q == EMIT && !evt_ready);
  end
  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      perf_steps_q <= '0;
      perf_stalls_q <= '0;
    end else begin
      perf_steps_q <= perf_steps_d;
      perf_stalls_q <= perf_stalls_d;
    end
  end
  assign perf_steps = perf_steps_q;
  assign perf_stalls = perf_stalls_q;
`endif
endmodule

// File: tb/tb_machine_step_sched.sv
// tb_machine_step_sched: directed bench with a transaction-level reference model and a stand-in Machine_step
module tb_machine_step_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] req_valid = '0;
  logic [259:0] req_data = '0;
  logic [3:0] req_ready;
  logic sched_halt = 1'b0;
  logic [666:0] step_ds;
  logic [64:0] step_ds1;
  logic [794:0] step_result;
  logic evt_valid;
  logic evt_ready = 1'b0;
  logic [94:0] evt_data;
  logic [32:0] evt_aux;
  logic [1:0] evt_src;
  logic busy;
  logic [666:0] machine_state;
`ifdef MACHINE_SCHED_PERF_EN
  logic [31:0] perf_steps, perf_stalls;
`endif
  int n_cmp = 0;
  int n_bad = 0;
  int cyc_n = 0;
  int gq[$];
  int gc[$];
  logic m_on = 1'b0;
  logic m_step = 1'b0;
  logic m_pend = 1'b0;
  int m_last = 3;
  logic [666:0] m_state = 667'd1;
  logic [64:0] m_cmd = '0;
  logic [1:0] m_src = '0;
  logic [94:0] m_evt_data = '0;
  logic [32:0] m_evt_aux = '0;
  logic [1:0] m_evt_src = '0;

  always #5 clk = ~clk;

  machine_step_sched #(.NUM_REQ(4), .SRC_W(2)) dut (
    .system1000(clk),
    .system1000_rst(rst),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .sched_halt(sched_halt),
    .step_ds(step_ds),
    .step_ds1(step_ds1),
    .step_result(step_result),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_data(evt_data),
    .evt_aux(evt_aux),
    .evt_src(evt_src),
    .busy(busy),
`ifdef MACHINE_SCHED_PERF_EN
    .perf_steps(perf_steps),
    .perf_stalls(perf_stalls),
`endif
    .machine_state(machine_state)
  );

  function automatic logic [794:0] ms(input logic [666:0] ds, input logic [64:0] c);
    logic [666:0] n;
    logic [94:0] e;
    logic [32:0] a;
    n = {ds[665:0], ds[666]} ^ {602'd0, c};
    e = {c[0], c[1], c[64:2], ds[29:0]};
    a = c[32:0] ^ ds[32:0];
    return {n, e, a};
  endfunction

  assign step_result = ms(step_ds, step_ds1);

  task automatic chk(input string nm, input logic [799:0] a, input logic [799:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", nm, a, e);
    end
  endtask

  task automatic cmp();
    logic [794:0] r;
    logic [3:0] er;
    int g;
    er = '0;
    g = -1;
    if (m_on) begin
      if (!m_step && !m_pend && !sched_halt && |req_valid) begin
        for (int k = 4; k >= 1; k--) if (req_valid[(m_last + k) % 4]) g = (m_last + k) % 4;
        er[g] = 1'b1;
      end
      chk("req_ready", 800'(req_ready), 800'(er));
      chk("busy", 800'(busy), 800'(m_step || m_pend));
      chk("machine_state", 800'(machine_state), 800'(m_state));
      chk("evt_valid", 800'(evt_valid), 800'(m_pend));
      if (m_pend) begin
        chk("evt_data", 800'(evt_data), 800'(m_evt_data));
        chk("evt_aux", 800'(evt_aux), 800'(m_evt_aux));
        chk("evt_src", 800'(evt_src), 800'(m_evt_src));
      end
      if (m_step) begin
        chk("step_ds1", 800'(step_ds1), 800'(m_cmd));
        r = ms(m_state, m_cmd);
        m_state = r[794:128];
        m_pend = |r[127:126];
        m_evt_data = r[127:33];
        m_evt_aux = r[32:0];
        m_evt_src = m_src;
        m_step = 1'b0;
      end else if (m_pend) begin
        if (evt_ready) m_pend = 1'b0;
      end else if (g >= 0) begin
        m_step = 1'b1;
        m_cmd = req_data[65*g +: 65];
        m_src = 2'(g);
        m_last = g;
        gq.push_back(g);
        gc.push_back(cyc_n);
      end
    end
    if (rst) begin
      m_on = 1'b1;
      m_state = 667'd1;
      m_step = 1'b0;
      m_pend = 1'b0;
      m_last = 3;
      m_cmd = '0;
    end
    cyc_n++;
  endtask

  task automatic cyc();
    @(negedge clk);
    cmp();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    sched_halt = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    int n0;
    do_reset();
    for (int i = 0; i < 5; i++) cyc();
    #1;
    chk("rst_state", 800'(machine_state), 800'(667'd1));
    chk("rst_busy", 800'(busy), 800'(0));
    chk("rst_req_ready", 800'(req_ready), 800'(0));
    chk("rst_evt_valid", 800'(evt_valid), 800'(0));
    chk("rst_evt_data", 800'(evt_data), 800'(0));
    chk("rst_evt_src", 800'(evt_src), 800'(0));
    chk("rst_step_ds1", 800'(step_ds1), 800'(0));

    for (int i = 0; i < 4; i++) req_data[65*i +: 65] = 65'(i * 8 + (i % 3));
    evt_ready = 1'b1;
    req_valid = 4'hF;
    gq.delete();
    for (int i = 0; i < 100 && gq.size() < 8; i++) cyc();
    for (int i = 0; i < 8; i++) chk($sformatf("rr_order%0d", i), 800'(gq.size() > i ? gq[i] : -1), 800'(i % 4));

    do_reset();
    evt_ready = 1'b0;
    req_data = '0;
    req_data[130 +: 65] = 65'h0_0000_0000_0000_0001;
    req_valid = 4'b0100;
    #1;
    chk("single_req_ready", 800'(req_ready), 800'(4'b0100));
    cyc();
    req_valid = 4'b0000;
    cyc();
    req_valid = 4'b0001;
    #1;
    chk("single_evt_valid", 800'(evt_valid), 800'(1));
    chk("single_evt_src", 800'(evt_src), 800'(2));
    chk("single_state", 800'(machine_state), 800'(667'd3));
    chk("single_evt_data", 800'(evt_data), 800'({2'b10, 92'd0, 1'b1}));
    for (int i = 0; i < 10; i++) cyc();
    #1;
    chk("stall_req_ready", 800'(req_ready), 800'(0));
    chk("stall_evt_valid", 800'(evt_valid), 800'(1));
`ifdef MACHINE_SCHED_PERF_EN
    chk("perf_stalls", 800'(perf_stalls), 800'(10));
    chk("perf_steps", 800'(perf_steps), 800'(1));
`endif
    evt_ready = 1'b1;
    cyc();
    #1;
    chk("after_hs_grant", 800'(req_ready), 800'(4'b0001));
    gc.delete();
    for (int i = 0; i < 6; i++) cyc();
    chk("noevt_gap0", 800'(gc.size() > 1 ? gc[1] - gc[0] : -1), 800'(2));
    chk("noevt_gap1", 800'(gc.size() > 2 ? gc[2] - gc[1] : -1), 800'(2));

    sched_halt = 1'b1;
    req_valid = 4'hF;
    for (int i = 0; i < 3; i++) cyc();
    n0 = gq.size();
    for (int i = 0; i < 4; i++) cyc();
    #1;
    chk("halt_busy", 800'(busy), 800'(0));
    chk("halt_req_ready", 800'(req_ready), 800'(0));
    chk("halt_no_grant", 800'(gq.size()), 800'(n0));

    sched_halt = 1'b0;
    req_valid = 4'b0010;
    req_data[65 +: 65] = 65'd9;
    n0 = gq.size();
    for (int i = 0; i < 10 && gq.size() == n0; i++) cyc();
    chk("mid_rst_grant_seen", 800'(gq.size()), 800'(n0 + 1));
    rst = 1'b1;
    req_valid = '0;
    cyc();
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", 800'(busy), 800'(0));
    chk("mid_rst_state", 800'(machine_state), 800'(667'd1));
    chk("mid_rst_evt_valid", 800'(evt_valid), 800'(0));
    for (int i = 0; i < 3; i++) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
